pdm_tx: RTL and testbench

Transmit-side counterpart of the PDM microphone receiver in the audio path. Accepts signed PCM samples over a valid/ready handshake and converts them with a first-order sigma-delta modulator into a 1-bit PDM stream. Generates its own PDM bit clock, so its outputs can drive the board's mono audio output (data plus shutdown/enable) or loop back into the microphone receiver for self-test.

---
 rtl/pdm_tx_pkg.sv | 16 +
 rtl/pdm_clkgen.sv | 70 +++++++
 rtl/pdm_tx.sv | 182 ++++++++++++++++++
 tb/tb_pdm_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_tx_pkg.sv
// -----------------------------------------------------------------------------
// pdm_tx_pkg
// Shared audio-path constants. The PDM microphone receiver and the PDM
// transmitter both derive their defaults from here so the two ends of a
// loopback always agree on bit clock rate, oversampling ratio and PCM width.
//   PCM_W        : PCM sample width (signed two's complement)
//   PDM_DIV_HALF : system clock cycles per half period of the PDM bit clock
//   PDM_OSR      : PDM bits per PCM sample
// -----------------------------------------------------------------------------
package pdm_tx_pkg;

  localparam int PCM_W        = 16;
  localparam int PDM_DIV_HALF = 25;
  localparam int PDM_OSR      = 64;

endpackage : pdm_tx_pkg

// File: rtl/pdm_clkgen.sv
// -----------------------------------------------------------------------------
// pdm_clkgen
// Divides the system clock down to the PDM bit clock and flags the cycle in
// which that bit clock falls, which is where the modulator advances.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   en       in   run enable; low holds the divider cleared and pdm_clk low
//   pdm_clk  out  PDM bit clock, 2*DIV_HALF clk cycles per period, 50 % duty
//   bit_step out  high during the cycle whose closing edge drives pdm_clk 1->0
// -----------------------------------------------------------------------------
module pdm_clkgen
  import pdm_tx_pkg::*;
#(
  parameter int DIV_HALF = PDM_DIV_HALF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic pdm_clk,
  output logic bit_step
);

  localparam int             DW       = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV_HALF - 1);

  logic [DW-1:0] div_cnt_r;
  logic [DW-1:0] div_cnt_nxt_s;
  logic          pdm_clk_r;
  logic          pdm_clk_nxt_s;
  logic          wrap_s;

  // Next-state for the half-period counter and the bit clock.
  always_comb begin
    div_cnt_nxt_s = div_cnt_r;
    pdm_clk_nxt_s = pdm_clk_r;
    wrap_s        = (div_cnt_r == DIV_LAST);
    if (!en) begin
      div_cnt_nxt_s = '0;
      pdm_clk_nxt_s = 1'b0;
    end else if (wrap_s) begin
      div_cnt_nxt_s = '0;
      pdm_clk_nxt_s = ~pdm_clk_r;
    end else begin
      div_cnt_nxt_s = div_cnt_r + DW'(1);
      pdm_clk_nxt_s = pdm_clk_r;
    end
  end

  // The strobe is decoded from registered state so it lines up with the
  // same clk edge that lowers pdm_clk; consumers register on that edge.
  always_comb begin
    bit_step = en && wrap_s && pdm_clk_r;
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= '0;
      pdm_clk_r <= 1'b0;
    end else begin
      div_cnt_r <= div_cnt_nxt_s;
      pdm_clk_r <= pdm_clk_nxt_s;
    end
  end

  assign pdm_clk = pdm_clk_r;

endmodule : pdm_clkgen

// File: rtl/pdm_tx.sv
// -----------------------------------------------------------------------------
// pdm_tx
// PCM-to-PDM transmitter. Signed PCM samples arrive over a valid/ready
// handshake into a one-entry holding register, are promoted to the current
// sample at each frame boundary (every OSR PDM bits) and converted by a
// first-order sigma-delta modulator into a 1-bit PDM stream with its own
// bit clock.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   en         in   run enable; low idles the modulator (samples retained)
//   s_data     in   PCM sample, W bits signed
//   s_valid    in   s_data valid
//   s_ready    out  holding register empty; accept on s_valid && s_ready
//   pdm_clk    out  PDM bit clock
//   pdm_data   out  PDM bit, changes only on the edge where pdm_clk falls
//   aud_sd     out  amplifier enable, registered copy of en
//   frame_tick out  one-cycle pulse at each sample boundary
//   underrun   out  one-cycle pulse when a boundary finds no new sample
// -----------------------------------------------------------------------------
module pdm_tx
  import pdm_tx_pkg::*;
#(
  parameter int W        = PCM_W,
  parameter int DIV_HALF = PDM_DIV_HALF,
  parameter int OSR      = PDM_OSR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         pdm_clk,
  output logic         pdm_data,
  output logic         aud_sd,
  output logic         frame_tick,
  output logic         underrun
);

  localparam int            BW       = $clog2(OSR);
  localparam logic [BW-1:0] BIT_LAST = BW'(OSR - 1);

  // Signed sample to offset-binary: flipping the sign bit adds 2^(W-1).
  function automatic logic [W-1:0] to_offset(input logic [W-1:0] x);
    return {~x[W-1], x[W-2:0]};
  endfunction

  logic          bit_step_s;
  logic          pdm_clk_s;

  logic [W-1:0]  acc_r;
  logic [W-1:0]  cur_r;
  logic [W-1:0]  nxt_r;
  logic          nxt_full_r;
  logic [BW-1:0] bit_cnt_r;
  logic          pdm_data_r;
  logic          frame_tick_r;
  logic          underrun_r;
  logic          aud_sd_r;

  logic [W-1:0]  acc_nxt_s;
  logic [W-1:0]  cur_nxt_s;
  logic [W-1:0]  nxt_nxt_s;
  logic          nxt_full_nxt_s;
  logic [BW-1:0] bit_cnt_nxt_s;
  logic          pdm_data_nxt_s;
  logic          frame_tick_nxt_s;
  logic          underrun_nxt_s;

  logic [W-1:0]  u_s;
  logic [W:0]    sum_s;
  logic          boundary_s;
  logic          accept_s;

  pdm_clkgen #(
    .DIV_HALF (DIV_HALF)
  ) u_clkgen (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pdm_clk  (pdm_clk_s),
    .bit_step (bit_step_s)
  );

  // Modulator arithmetic and handshake decode.
  always_comb begin
    u_s        = to_offset(cur_r);
    sum_s      = {1'b0, acc_r} + {1'b0, u_s};
    boundary_s = bit_step_s && (bit_cnt_r == BIT_LAST);
    accept_s   = s_valid && !nxt_full_r;
  end

  // Next-state for modulator, frame counter and holding register.
  always_comb begin
    acc_nxt_s        = acc_r;
    cur_nxt_s        = cur_r;
    nxt_nxt_s        = nxt_r;
    nxt_full_nxt_s   = nxt_full_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    pdm_data_nxt_s   = pdm_data_r;
    frame_tick_nxt_s = 1'b0;
    underrun_nxt_s   = 1'b0;

    if (!en) begin
      // Idle: restart the frame on re-enable but keep the queued samples.
      acc_nxt_s      = '0;
      bit_cnt_nxt_s  = '0;
      pdm_data_nxt_s = 1'b0;
    end else if (bit_step_s) begin
      // The boundary bit still uses the outgoing sample; a newly loaded
      // sample only affects the following bit step.
      pdm_data_nxt_s = sum_s[W];
      acc_nxt_s      = sum_s[W-1:0];
      if (boundary_s) begin
        bit_cnt_nxt_s    = '0;
        frame_tick_nxt_s = 1'b1;
        if (nxt_full_r) begin
          cur_nxt_s      = nxt_r;
          nxt_full_nxt_s = 1'b0;
        end else begin
          underrun_nxt_s = 1'b1;
        end
      end else begin
        bit_cnt_nxt_s = bit_cnt_r + BW'(1);
      end
    end else begin
      pdm_data_nxt_s = pdm_data_r;
    end

    // Accept only fires while the register is empty, so it never collides
    // with a boundary transfer; an accept at an empty boundary lands in nxt
    // for the next frame while underrun still reports this one.
    if (accept_s) begin
      nxt_nxt_s      = s_data;
      nxt_full_nxt_s = 1'b1;
    end else begin
      nxt_nxt_s = nxt_nxt_s;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r        <= '0;
      cur_r        <= '0;
      nxt_r        <= '0;
      nxt_full_r   <= 1'b0;
      bit_cnt_r    <= '0;
      pdm_data_r   <= 1'b0;
      frame_tick_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      acc_r        <= acc_nxt_s;
      cur_r        <= cur_nxt_s;
      nxt_r        <= nxt_nxt_s;
      nxt_full_r   <= nxt_full_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      pdm_data_r   <= pdm_data_nxt_s;
      frame_tick_r <= frame_tick_nxt_s;
      underrun_r   <= underrun_nxt_s;
    end
  end

  // Amplifier enable follows en one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      aud_sd_r <= 1'b0;
    end else begin
      aud_sd_r <= en;
    end
  end

  assign s_ready    = ~nxt_full_r;
  assign pdm_clk    = pdm_clk_s;
  assign pdm_data   = pdm_data_r;
  assign aud_sd     = aud_sd_r;
  assign frame_tick = frame_tick_r;
  assign underrun   = underrun_r;

endmodule : pdm_tx

// File: tb/tb_pdm_tx.sv
// -----------------------------------------------------------------------------
// tb_pdm_tx
// Self-checking bench for pdm_tx. A reference model counts enabled clk edges
// and derives the bit clock, bit steps, frame boundaries and sigma-delta
// output from integer arithmetic; every output is compared each cycle, plus
// directed density/spacing checks.
// -----------------------------------------------------------------------------
module tb_pdm_tx;
  import pdm_tx_pkg::*;

  localparam int W     = PCM_W;
  localparam int DH    = PDM_DIV_HALF;
  localparam int OSR   = PDM_OSR;
  localparam int PER   = 2 * DH;
  localparam int FRAME = OSR * PER;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic         pdm_clk;
  logic         pdm_data;
  logic         aud_sd;
  logic         frame_tick;
  logic         underrun;

  always #5 clk = ~clk;

  pdm_tx #(
    .W        (W),
    .DIV_HALF (DH),
    .OSR      (OSR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .pdm_clk    (pdm_clk),
    .pdm_data   (pdm_data),
    .aud_sd     (aud_sd),
    .frame_tick (frame_tick),
    .underrun   (underrun)
  );

  // Reference model state
  int     k_m;
  longint acc_m;
  int     cur_m;
  int     nxt_m;
  bit     full_m;
  bit     data_m;
  bit     ft_m;
  bit     ur_m;
  bit     aud_m;

  // Bench bookkeeping
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   last_boundary;
  bit   last_dut_accept;
  int   frame_ones;
  int   last_frame_ones;
  int   underrun_cnt;
  int   last_ft_cyc;
  int   ft_gap;
  int   bad_edges;
  logic prev_clk;
  logic prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit model_acc;
    bit en_was;
    bit rst_was;
    int u;
    int exp_clk;
    model_acc       = s_valid && !full_m && !reset;
    last_dut_accept = (s_valid === 1'b1) && (s_ready === 1'b1) && !reset;
    en_was          = en;
    rst_was         = reset;
    @(posedge clk);
    cyc++;
    last_boundary = 1'b0;
    if (rst_was) begin
      k_m = 0; acc_m = 0; cur_m = 0; nxt_m = 0; full_m = 1'b0;
      data_m = 1'b0; ft_m = 1'b0; ur_m = 1'b0; aud_m = 1'b0;
    end else begin
      aud_m = en_was;
      ft_m  = 1'b0;
      ur_m  = 1'b0;
      if (!en_was) begin
        k_m = 0; acc_m = 0; data_m = 1'b0;
      end else begin
        k_m++;
        if (k_m % PER == 0) begin
          u      = cur_m + 2 ** (W - 1);
          acc_m  = acc_m + u;
          data_m = (acc_m >= 2 ** W);
          acc_m  = acc_m % (2 ** W);
          if ((k_m / PER) % OSR == 0) begin
            ft_m = 1'b1;
            last_boundary = 1'b1;
            if (full_m) begin
              cur_m  = nxt_m;
              full_m = 1'b0;
            end else begin
              ur_m = 1'b1;
            end
          end
        end
      end
      if (model_acc) begin
        nxt_m  = int'($signed(s_data));
        full_m = 1'b1;
      end
    end
    #1;
    exp_clk = (k_m / DH) % 2;
    chk("pdm_clk",    64'(pdm_clk),    64'(exp_clk));
    chk("pdm_data",   64'(pdm_data),   64'(data_m));
    chk("frame_tick", 64'(frame_tick), 64'(ft_m));
    chk("underrun",   64'(underrun),   64'(ur_m));
    chk("s_ready",    64'(s_ready),    64'(!full_m));
    chk("aud_sd",     64'(aud_sd),     64'(aud_m));

    if (rst_was || !en_was) begin
      frame_ones  = 0;
      last_ft_cyc = -1;
    end else begin
      if (k_m % PER == 0) frame_ones += (pdm_data === 1'b1) ? 1 : 0;
      if (last_boundary) begin
        last_frame_ones = frame_ones;
        frame_ones = 0;
      end
      if (pdm_data !== prev_data && !(prev_clk === 1'b1 && pdm_clk === 1'b0))
        bad_edges++;
    end
    if (frame_tick === 1'b1) begin
      if (last_ft_cyc >= 0) ft_gap = cyc - last_ft_cyc;
      last_ft_cyc = cyc;
    end
    if (underrun === 1'b1) underrun_cnt++;
    prev_clk  = pdm_clk;
    prev_data = pdm_data;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to_boundary();
    bit found;
    found = 1'b0;
    for (int i = 0; i < FRAME + PER; i++) begin
      tick();
      if (last_boundary) begin
        found = 1'b1;
        break;
      end
    end
    chk("boundary_wait", 64'(found), 64'd1);
  endtask

  task automatic send(input logic [W-1:0] d, output int waited);
    bit got;
    got     = 1'b0;
    waited  = 0;
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < FRAME + PER; i++) begin
      tick();
      waited++;
      if (last_dut_accept) begin
        got = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    chk("accept_wait", 64'(got), 64'd1);
  endtask

  initial begin
    int w;
    int cnt;
    bit seen;
    reset = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0;
    k_m = 0; acc_m = 0; cur_m = 0; nxt_m = 0; full_m = 1'b0;
    data_m = 1'b0; ft_m = 1'b0; ur_m = 1'b0; aud_m = 1'b0;
    frame_ones = 0; last_frame_ones = -1; underrun_cnt = 0;
    last_ft_cyc = -1; ft_gap = -1; bad_edges = 0;
    prev_clk = 1'b0; prev_data = 1'b0;

    // Reset values
    run(2);
    reset = 1'b0;
    en    = 1'b1;

    // Idle stream: cur=0 gives 0,1,0,1..., underrun at every boundary
    underrun_cnt = 0;
    run_to_boundary();
    run_to_boundary();
    chk("idle_density", 64'(last_frame_ones), 64'd32);
    chk("idle_underruns", 64'(underrun_cnt), 64'd2);
    chk("frame_spacing", 64'(ft_gap), 64'(FRAME));

    // Full-scale negative: whole frame of zeros
    send(16'h8000, w);
    chk("first_accept_wait", 64'(w), 64'd1);
    run_to_boundary();
    run_to_boundary();
    chk("min_density", 64'(last_frame_ones), 64'd0);

    // Full-scale positive: at least 63 ones
    send(16'h7FFF, w);
    run_to_boundary();
    run_to_boundary();
    chk("max_density_ge63", 64'(last_frame_ones >= 63), 64'd1);

    // Half-scale positive: exactly 48 ones per frame
    send(16'h4000, w);
    run_to_boundary();
    run_to_boundary();
    chk("density_48", 64'(last_frame_ones), 64'd48);

    // Back-to-back samples right after a boundary
    run_to_boundary();
    underrun_cnt = 0;
    send(W'($urandom), w);
    chk("b2b_first_wait", 64'(w), 64'd1);
    send(W'($urandom), w);
    chk("b2b_second_blocked", 64'(w > 1), 64'd1);
    chk("b2b_no_underrun", 64'(underrun_cnt), 64'd0);
    run_to_boundary();

    // Reset at bit 30 of a frame
    seen = 1'b0;
    for (int i = 0; i < FRAME + PER; i++) begin
      tick();
      if (k_m % PER == 0 && (k_m / PER) % OSR == 30) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reach_bit30", 64'(seen), 64'd1);
    reset = 1'b1;
    tick();
    chk("rst_pdm_clk", 64'(pdm_clk), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    reset = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      cnt++;
      if (frame_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("restart_tick_seen", 64'(seen), 64'd1);
    chk("restart_frame_len", 64'(cnt), 64'(FRAME));

    // Drop en with a queued sample; it must survive the idle period
    send(16'h8000, w);
    run(500);
    en = 1'b0;
    run(3);
    chk("idle_pdm_clk", 64'(pdm_clk), 64'd0);
    chk("idle_pdm_data", 64'(pdm_data), 64'd0);
    run(100);
    en = 1'b1;
    run_to_boundary();
    run_to_boundary();
    chk("en_drop_nxt_kept", 64'(last_frame_ones), 64'd0);

    // Random samples with random gaps (may underrun)
    for (int f = 0; f < 4; f++) begin
      run($urandom_range(1, 2 * FRAME / 3));
      send(W'($urandom), w);
    end
    run_to_boundary();
    run_to_boundary();

    chk("data_changes_on_fall", 64'(bad_edges), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pdm_tx
